// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller: FSM state,
// divider calculation and default clocking constants.
package uart_pkg;

    localparam int CLK_HZ_DEF = 50_000_000;
    localparam int BAUD_DEF   = 115_200;
    localparam int OVS_DEF    = 16;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Oversample divider, truncated, never below 1.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        int d;
        d = clk_hz / (baud * ovs);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample strobe generator: counts 0..DIV-1 while run is high and holds
// zero otherwise, so each run period starts with a full DIV-cycle interval.
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud strobe, rx_done edge capture into a small
// FIFO, overrun flag. UART_RX_CTRL_OVR_CNT_EN adds a saturating drop counter.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int BAUD   = BAUD_DEF,
    parameter int OVS    = OVS_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    output logic                     tick,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    output logic                     m_valid,
    output logic [7:0]               m_data,
    input  logic                     m_ready,
    output logic                     overrun,
    input  logic                     clr_ovr,
    output logic [$clog2(DEPTH):0]   level
`ifdef UART_RX_CTRL_OVR_CNT_EN
    ,
    output logic [7:0]               ovr_cnt
`endif
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          rx_prev_q;
    logic          ovr_q, ovr_d;
    logic [7:0]    mem_q [DEPTH];

    logic          empty, full, push_ev, pop, wr_en, drop;
    logic [PW-1:0] lvl;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .run   (state_q == RUN),
        .tick  (tick)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign lvl     = wr_q - rd_q;
    assign push_ev = rx_done && !rx_prev_q && (state_q == RUN);
    assign pop     = !empty && m_ready;
    assign wr_en   = push_ev && (!full || pop);
    assign drop    = push_ev && full && !pop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OFF:     if (en) state_d = RUN;
            RUN:     if (!en) state_d = (lvl != '0) ? DRAIN : OFF;
            DRAIN:   if (en) state_d = RUN;
                     else if (lvl == '0) state_d = OFF;
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d  = pop   ? rd_q + 1'b1 : rd_q;
        ovr_d = ovr_q;
        if (drop)         ovr_d = 1'b1;
        else if (clr_ovr) ovr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= OFF;
            wr_q      <= '0;
            rd_q      <= '0;
            rx_prev_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rx_prev_q <= rx_done;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) mem_q[wr_q[AW-1:0]] <= rx_data;
    end

`ifdef UART_RX_CTRL_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (drop)         ovr_cnt_d = (ovr_cnt_q == 8'hFF) ? ovr_cnt_q : ovr_cnt_q + 8'd1;
        else if (clr_ovr) ovr_cnt_d = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!reset) ovr_cnt_q <= 8'h00;
        else        ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovr_cnt = ovr_cnt_q;
`endif

    // Storage is not reset; the head is masked while empty.
    assign m_valid = !empty;
    assign m_data  = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    assign overrun = ovr_q;
    assign level   = lvl;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: fixed vector table, hand-written corner sequences
// and random traffic, all compared against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int DIV_M = 50_000_000 / (115_200 * 16);

    logic       clk = 1'b0;
    logic       reset, en, rx_done, m_ready, clr_ovr;
    logic [7:0] rx_data;
    logic       tick, m_valid, overrun;
    logic [7:0] m_data;
    logic [2:0] level;
`ifdef UART_RX_CTRL_OVR_CNT_EN
    logic [7:0] ovr_cnt;
`endif

    int checks = 0;
    int failures = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .tick    (tick),
        .rx_done (rx_done),
        .rx_data (rx_data),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .overrun (overrun),
        .clr_ovr (clr_ovr),
        .level   (level)
`ifdef UART_RX_CTRL_OVR_CNT_EN
        ,
        .ovr_cnt (ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: byte queue, mode 0=off 1=run 2=drain, cycles spent in run.
    logic [7:0] mq[$];
    int mode = 0;
    int run_cyc = 0;
    bit prev = 1'b0;
    bit m_ovr = 1'b0;
    int m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  old_lvl, old_mode;
        bit  push, pop, drop;
        old_lvl = mq.size();
        if (!reset) begin
            mq.delete();
            mode = 0; run_cyc = 0; prev = 1'b0; m_ovr = 1'b0; m_cnt = 0;
            return;
        end
        push = rx_done && !prev && mode == 1;
        pop  = old_lvl > 0 && m_ready;
        drop = push && old_lvl == DEPTH && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(rx_data);
        if (drop) begin
            m_ovr = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else if (clr_ovr) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
        old_mode = mode;
        case (mode)
            0: if (en) mode = 1;
            1: if (!en) mode = (old_lvl > 0) ? 2 : 0;
            default: if (en) mode = 1; else if (old_lvl == 0) mode = 0;
        endcase
        run_cyc = (mode == 1 && old_mode == 1) ? run_cyc + 1 : 0;
        prev = rx_done;
    endtask

    task automatic step();
        logic [7:0] head;
        @(posedge clk);
        model_edge();
        #1;
        head = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("model_tick", 32'(tick), 32'(mode == 1 && (run_cyc % DIV_M) == DIV_M - 1));
        chk("model_m_valid", 32'(m_valid), 32'(mq.size() > 0));
        chk("model_m_data", 32'(m_data), 32'(head));
        chk("model_level", 32'(level), 32'(mq.size()));
        chk("model_overrun", 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_CTRL_OVR_CNT_EN
        chk("model_ovr_cnt", 32'(ovr_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        rx_data = b; rx_done = 1'b1; step();
        rx_done = 1'b0; step();
    endtask

    typedef struct packed {
        logic       rst_n, en, done;
        logic [7:0] data;
        logic       rdy, clr;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] el;
        logic       eo;
    } vec_t;

    function automatic vec_t mk(logic r, logic e, logic d, logic [7:0] dat, logic rd,
                                logic c, logic ev, logic [7:0] ed, logic [2:0] el, logic eo);
        vec_t v;
        v.rst_n = r; v.en = e; v.done = d; v.data = dat; v.rdy = rd; v.clr = c;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
        return v;
    endfunction

    vec_t tbl[10];

    initial begin
        int k;
        reset = 1'b0; en = 1'b0; rx_done = 1'b0; rx_data = 8'h00; m_ready = 1'b0; clr_ovr = 1'b0;

        // Reset, enable, held rx_done gives one push, then ordered pops.
        tbl[0] = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        tbl[1] = mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        tbl[2] = mk(1, 1, 1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0);
        tbl[3] = mk(1, 1, 1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0);
        tbl[4] = mk(1, 1, 1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0);
        tbl[5] = mk(1, 1, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 0);
        tbl[6] = mk(1, 1, 1, 8'h5A, 0, 0, 1, 8'hA5, 2, 0);
        tbl[7] = mk(1, 1, 0, 8'h00, 1, 0, 1, 8'h5A, 1, 0);
        tbl[8] = mk(1, 1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        tbl[9] = mk(1, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);

        for (int i = 0; i < 10; i++) begin
            reset = tbl[i].rst_n; en = tbl[i].en; rx_done = tbl[i].done;
            rx_data = tbl[i].data; m_ready = tbl[i].rdy; clr_ovr = tbl[i].clr;
            step();
            chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].el));
            chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].eo));
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'd0);
        end
        clr_ovr = 1'b0;

        // Tick period from a fresh RUN entry.
        reset = 1'b0; en = 1'b0; step();
        reset = 1'b1; en = 1'b1; step();
        k = 0;
        while (!tick && k < 100) begin step(); k++; end
        chk("first_tick_delay", 32'(k), 32'd26);
        k = 0;
        do begin step(); k++; end while (!tick && k < 100);
        chk("tick_period", 32'(k), 32'd27);
        en = 1'b0; step();
        chk("tick_off_after_en0", 32'(tick), 32'd0);

        // Overrun with five pushes into four entries, then full push+pop.
        reset = 1'b0; step();
        reset = 1'b1; en = 1'b1; step();
        for (int i = 0; i < 5; i++) pulse_byte(8'h10 + 8'(i));
        chk("ovr_level", 32'(level), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_head", 32'(m_data), 32'h10);
`ifdef UART_RX_CTRL_OVR_CNT_EN
        chk("ovr_cnt", 32'(ovr_cnt), 32'd1);
`endif
        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        rx_data = 8'h77; rx_done = 1'b1; m_ready = 1'b1; step();
        rx_done = 1'b0; m_ready = 1'b0;
        chk("full_pushpop_level", 32'(level), 32'd4);
        chk("full_pushpop_ovr", 32'(overrun), 32'd0);
        chk("full_pushpop_head", 32'(m_data), 32'h11);
        step();

        // Drain: pushes ignored after en drops, pops continue.
        reset = 1'b0; step();
        reset = 1'b1; en = 1'b1; step();
        pulse_byte(8'hAA);
        pulse_byte(8'hBB);
        en = 1'b0; step();
        pulse_byte(8'hCC);
        chk("drain_push_ignored", 32'(level), 32'd2);
        chk("drain_ovr_clear", 32'(overrun), 32'd0);
        m_ready = 1'b1; step();
        chk("drain_pop1_head", 32'(m_data), 32'hBB);
        step(); m_ready = 1'b0;
        chk("drain_empty", 32'(m_valid), 32'd0);
        step();
        pulse_byte(8'hDD);
        chk("off_push_ignored", 32'(level), 32'd0);

        // Reset in the middle of RUN.
        en = 1'b1; step();
        pulse_byte(8'h33);
        step();
        reset = 1'b0; step();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 599) != 0);
            en      = ($urandom_range(0, 15) != 0);
            rx_done = ($urandom_range(0, 2) == 0);
            rx_data = 8'($urandom);
            m_ready = (i % 1000 < 500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
            clr_ovr = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
